dmem_responder: RTL and testbench

- Byte-lane data-memory responder: the memory-side end of the load/store request interface.
- Accepts one word-addressed request at a time over a valid/ready request channel.
- Performs a byte-enabled read or write on four internal byte banks.
- Returns the result over a valid/ready response channel with backpressure.
- Replaces direct combinational RAM access so the core can stall on memory.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Byte-lane data-memory responder. This is the memory-side end of the core's
// load/store request interface. It accepts one word-addressed request at a
// time, performs a byte-enabled read or write on four byte banks, and returns
// the result over a response channel that can be held off by the requester.
//
// Ports:
//   clk         - clock; all state updates on the rising edge
//   reset_n     - asynchronous active-low reset
//   req_valid   - request present
//   req_ready   - responder can accept a request (IDLE only)
//   req_addr    - byte address; bits [1:0] ignored, word index = req_addr[11:2]
//   req_we      - 1 = write, 0 = read
//   req_be      - byte-lane enables, bit i covers data bits [8i+7:8i]
//   req_wdata   - lane-aligned write data
//   rsp_valid   - response present
//   rsp_ready   - requester accepts the response
//   rsp_rdata   - read data with disabled lanes forced to zero
//   rsp_err     - request was rejected because of an illegal byte-enable pattern
//
// Flow: IDLE (capture) -> ACCESS (bank write or synchronous read) -> RESP
// (hold the response until rsp_ready). A new request can be accepted every
// third cycle at best.

module dmem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int NUM_MEM_BLOCKS = 4,
    parameter int ADDRESS_SPACE  = 4096
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [$clog2(ADDRESS_SPACE)-1:0] req_addr,
    input  logic                             req_we,
    input  logic [NUM_MEM_BLOCKS-1:0]        req_be,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err
);

    localparam int WORD_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic                      we_q, we_d;
    logic [NUM_MEM_BLOCKS-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      legal_q, legal_d;

    logic [NUM_MEM_BLOCKS-1:0] bank_we;
    logic                      bank_re;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic [DATA_WIDTH-1:0]     lane_mask;

    // The low address bits select a byte within the word; lane selection is
    // carried entirely by req_be, so these bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    // Only naturally aligned byte, halfword and word accesses are allowed.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    endfunction

    // Next-state and request capture. The request is only sampled in IDLE,
    // so the requester may change req_* freely while a transaction runs.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        legal_d = legal_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    word_d  = req_addr[2 +: WORD_W];
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    legal_d = be_legal(req_be);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and captured-request registers. Reset puts the FSM straight
    // back to IDLE, which also kills any pending bank write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            legal_q <= legal_d;
        end
    end

    // Bank strobes are only active during ACCESS for a legal request.
    always_comb begin
        bank_we = '0;
        bank_re = 1'b0;
        if (state_q == ST_ACCESS && legal_q) begin
            if (we_q) begin
                bank_we = be_q;
            end else begin
                bank_re = 1'b1;
            end
        end
    end

    // One byte-wide bank per lane with a registered read port, so the read
    // data is ready at the start of RESP.
    for (genvar i = 0; i < NUM_MEM_BLOCKS; i++) begin : g_bank
        logic [7:0] bank [DEPTH];
        logic [7:0] rd_lane_q;

        always_ff @(posedge clk) begin
            if (bank_we[i]) begin
                bank[word_q] <= wdata_q[8*i +: 8];
            end
            if (bank_re) begin
                rd_lane_q <= bank[word_q];
            end
        end

        assign rd_word[8*i +: 8] = rd_lane_q;
    end

    // Expand the captured byte enables into a bit mask for the read data.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_MEM_BLOCKS; i++) begin
            lane_mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    // Outputs decode from the FSM state; since the state register resets
    // asynchronously, the response outputs drop as soon as reset_n falls.
    always_comb begin
        req_ready = reset_n && (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && !legal_q;
        rsp_rdata = '0;
        if (state_q == ST_RESP && legal_q && !we_q) begin
            rsp_rdata = rd_word & lane_mask;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//
// Directed, table-driven bench for dmem_responder. A table of transactions
// with hand-computed results is replayed in order, followed by hand-written
// sequences for response backpressure and reset in the middle of a
// transaction.

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks_run  = 0;
    int checks_fail = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    dmem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_run++;
        if (act !== exp) begin
            checks_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one complete transaction with rsp_ready already high and check
    // handshake timing plus the returned response.
    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        check_output({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_be    = v.be;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h5A5A_5A5A;
        check_output({tag, ".valid_access"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_output({tag, ".valid_resp"}, {31'd0, rsp_valid}, 32'd1);
        check_output({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
        check_output({tag, ".err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        @(posedge clk);
        #1;
        check_output({tag, ".valid_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        // we, addr, be, wdata, expected rdata, expected err
        vecs[0]  = '{1'b1, 12'h010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 12'h010, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 12'h010, 4'b0100, 32'h00AA_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 12'h010, 4'b1111, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 12'h010, 4'b0011, 32'h0000_0000, 32'h0000_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 12'h010, 4'b0110, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 12'h010, 4'b1111, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 12'h013, 4'b1100, 32'h0000_0000, 32'hDEAA_0000, 1'b0};
        vecs[8]  = '{1'b1, 12'hFFC, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b1, 12'h000, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 12'hFFC, 4'b1111, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[12] = '{1'b0, 12'h000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 12'h000, 4'b1000, 32'hAB00_0000, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 12'h000, 4'b1111, 32'h0000_0000, 32'hABFE_F00D, 1'b0};
        vecs[15] = '{1'b0, 12'h000, 4'b0010, 32'h0000_0000, 32'h0000_F000, 1'b0};
        vecs[16] = '{1'b0, 12'h000, 4'b1010, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[17] = '{1'b0, 12'h000, 4'b0001, 32'h0000_0000, 32'h0000_000D, 1'b0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset asserted: nothing may be offered or accepted.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset.req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_output("reset.req_ready", {31'd0, req_ready}, 32'd1);
        check_output("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("reset.rsp_rdata", rsp_rdata, 32'd0);
        check_output("reset.rsp_err", {31'd0, rsp_err}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response must hold steady while rsp_ready is low and
        // a new request waiting on req_valid must not be taken.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h010;
        req_be    = 4'b1111;
        @(posedge clk);
        #1;
        req_addr = 12'h000;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_output($sformatf("bp.valid%0d", c), {31'd0, rsp_valid}, 32'd1);
            check_output($sformatf("bp.rdata%0d", c), rsp_rdata, 32'hDEAA_BEEF);
            check_output($sformatf("bp.req_ready%0d", c), {31'd0, req_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        check_output("bp.still_held", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp.released_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("bp.released_ready", {31'd0, req_ready}, 32'd1);
        // The request still held on req_valid is taken on the following edge.
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("bp.next_access", {31'd0, rsp_valid}, 32'd0);
        check_output("bp.next_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_output("bp.next_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("bp.next_rdata", rsp_rdata, 32'hABFE_F00D);
        @(posedge clk);
        #1;

        // Reset during RESP drops the response without a clock edge.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'hFFC;
        req_be    = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("rst_resp.valid_before", {31'd0, rsp_valid}, 32'd1);
        check_output("rst_resp.rdata_before", rsp_rdata, 32'h1234_5678);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("rst_resp.valid", {31'd0, rsp_valid}, 32'd0);
        check_output("rst_resp.rdata", rsp_rdata, 32'd0);
        check_output("rst_resp.req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;

        // Reset during ACCESS of a write: the write must never land.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h000;
        req_be    = 4'b1111;
        req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus('{1'b0, 12'h000, 4'b1111, 32'h0, 32'hABFE_F00D, 1'b0}, "rst_access");

        $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
